sprite_mover: RTL and testbench
===============================

SPRITE_MOVER -- requirements
Module: sprite_mover

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- X_SCREEN, 160, screen width in pixels.
- Y_SCREEN, 120, screen height in pixels.
- SPR_W, 11, sprite width.
- SPR_H, 10, sprite height.
- X_START, 73, home x.
- Y_START, 105, home y (fixed row).
- STEP, 5, pixels per move.
- HOLD_CYCLES, 4, post-move lockout length in cycles.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, input, 1, single clock; all state updates on its rising edge.
- reset, input, 1, asynchronous active-low reset.
- start, input, 1, begin game (level).
- left, input, 1, move-left command (level).
- right, input, 1, move-right command (level).
- rom_addr, output, 7, sprite ROM address, row-major cy*SPR_W+cx.
- rom_q, input, 3, sprite ROM data, valid 1 cycle after rom_addr.
- xout, output, 8, pixel x.
- yout, output, 7, pixel y.
- colourOut, output, 3, pixel colour.
- drawEn, output, 1, pixel write strobe.
- ready, output, 1, high only in READY.
- hitEdge, output, 1, single-cycle edge-event pulse.
- xpos, output, 8, current sprite x.

Function
REQ-003 The FSM SHALL have the states IDLE, CLEAR, DRAW, READY, ERASE, DRAW_NEW and HOLD.
REQ-004 IDLE SHALL go to CLEAR when start=1; start SHALL be ignored in every other state.
REQ-005 CLEAR SHALL write black (0) to every pixel, raster order x-fastest from (0,0) to (X_SCREEN-1,Y_SCREEN-1), one pixel per cycle with drawEn=1, then go to DRAW.
REQ-006 DRAW SHALL scan cx 0..SPR_W-1, cy 0..SPR_H-1 at one address per cycle with xpos=X_START.
REQ-007 In DRAW, each ROM read SHALL produce a pixel one cycle later: xout=xpos+cx, yout=Y_START+cy, colourOut=rom_q, drawEn=1; the state SHALL go to READY after the final pixel is emitted.
REQ-008 In READY, left=1 with right=0 SHALL go to ERASE with direction L, and right=1 with left=0 SHALL go to ERASE with direction R.
REQ-009 In READY, left=right=1 or left=right=0 SHALL cause no action.
REQ-010 ERASE SHALL write SPR_W*SPR_H black pixels over the box at the current xpos.
REQ-011 On the last ERASE pixel, xpos SHALL update per REQ-012 and REQ-013, then the state SHALL go to DRAW_NEW.
REQ-012 The candidate position SHALL be computed 9 bits signed: xpos-STEP for L, xpos+STEP for R.
REQ-013 The candidate is in range when 0 <= cand <= X_SCREEN-SPR_W; an in-range candidate SHALL be taken; out-of-range handling SHALL be per Configuration.
REQ-014 DRAW_NEW SHALL draw the sprite at the new xpos with REQ-007 timing, then go to HOLD.
REQ-015 HOLD SHALL last exactly HOLD_CYCLES cycles with drawEn=0 and commands ignored, then go to READY.
REQ-016 The pixel-output latency from the address counter SHALL be 1 cycle; drawEn SHALL be 0 in IDLE, READY and HOLD.
REQ-017 A draw or erase pass SHALL take SPR_W*SPR_H+1 cycles.

Reset
REQ-018 reset=0 SHALL asynchronously force state=IDLE, xpos=X_START, rom_addr=0, xout=0, yout=0, colourOut=0, drawEn=0, hitEdge=0 and all counters to 0.
REQ-019 Reset asserted mid-pass SHALL abort the pass with no further drawEn pulses; after release, the block SHALL require start again.

Configuration
REQ-020 When SPRITE_WRAP_EN is defined, an out-of-range candidate SHALL wrap: below 0 gives xpos=X_SCREEN-SPR_W, above the maximum gives xpos=0; hitEdge SHALL pulse for 1 cycle.
REQ-021 When SPRITE_WRAP_EN is undefined, an out-of-range candidate SHALL clamp to 0 or X_SCREEN-SPR_W; hitEdge SHALL pulse for 1 cycle; the erase and redraw still occur.

Verification
REQ-022 Reset release then start=1 -> exactly 19200 black drawEn pixels, then 110 sprite pixels at x 73..83, y 105..114, then ready=1.
REQ-023 From READY, left pulse -> 110 black pixels at x 73..83, xpos=68, 110 sprite pixels at x 68..78, 4 HOLD cycles, ready=1.
REQ-024 xpos=3, left, SPRITE_WRAP_EN undefined -> xpos=0 and one hitEdge pulse; with SPRITE_WRAP_EN defined -> xpos=149 and one hitEdge pulse.
REQ-025 left=right=1 in READY, and right asserted during HOLD -> no state change and xpos unchanged.
REQ-026 reset asserted at DRAW_NEW pixel 50 -> drawEn=0 immediately and xpos=73; start is required to redraw.

Source files
------------

// File: rtl/sprite_mover.sv
`default_nettype none
// sprite_mover: clears the screen, draws a ROM sprite on a fixed row and moves it left/right.
// Build option SPRITE_WRAP_EN: wrap at the screen edges instead of clamping.
module sprite_mover #(
    parameter int X_SCREEN    = 160,
    parameter int Y_SCREEN    = 120,
    parameter int SPR_W       = 11,
    parameter int SPR_H       = 10,
    parameter int X_START     = 73,
    parameter int Y_START     = 105,
    parameter int STEP        = 5,
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       left,
    input  logic       right,
    output logic [6:0] rom_addr,
    input  logic [2:0] rom_q,
    output logic [7:0] xout,
    output logic [6:0] yout,
    output logic [2:0] colourOut,
    output logic       drawEn,
    output logic       ready,
    output logic       hitEdge,
    output logic [7:0] xpos
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLEAR    = 3'd1,
        DRAW     = 3'd2,
        READY    = 3'd3,
        ERASE    = 3'd4,
        DRAW_NEW = 3'd5,
        HOLD     = 3'd6
    } state_t;

    localparam logic [7:0]        X_LAST    = 8'(X_SCREEN - 1);
    localparam logic [6:0]        Y_LAST    = 7'(Y_SCREEN - 1);
    localparam logic [7:0]        CX_LAST   = 8'(SPR_W - 1);
    localparam logic [6:0]        CY_LAST   = 7'(SPR_H - 1);
    localparam logic [7:0]        X_HOME    = 8'(X_START);
    localparam logic [6:0]        Y_ROW     = 7'(Y_START);
    localparam logic signed [8:0] X_MAX     = 9'(X_SCREEN - SPR_W);
    localparam logic signed [8:0] STEP_S    = 9'(STEP);
    localparam logic [7:0]        HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t            state;
    logic [7:0]        cx;
    logic [6:0]        cy;
    logic              scan_done;
    logic              move_left;
    logic              from_rom;
    logic [7:0]        hold_cnt;
    logic              box_last;
    logic signed [8:0] cand;
    logic [7:0]        next_x;
    logic              edge_hit;

    assign box_last = (cx == CX_LAST) && (cy == CY_LAST);
    assign ready    = (state == READY);
    // The sprite ROM is synchronous, so its data lines up with the registered pixel coordinates.
    assign colourOut = from_rom ? rom_q : 3'd0;

    always_comb begin
        cand     = move_left ? ($signed({1'b0, xpos}) - STEP_S) : ($signed({1'b0, xpos}) + STEP_S);
        next_x   = cand[7:0];
        edge_hit = 1'b0;
        if (cand[8]) begin
            edge_hit = 1'b1;
`ifdef SPRITE_WRAP_EN
            next_x = X_MAX[7:0];
`else
            next_x = 8'd0;
`endif
        end else if (cand > X_MAX) begin
            edge_hit = 1'b1;
`ifdef SPRITE_WRAP_EN
            next_x = 8'd0;
`else
            next_x = X_MAX[7:0];
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            xpos      <= X_HOME;
            rom_addr  <= 7'd0;
            xout      <= 8'd0;
            yout      <= 7'd0;
            drawEn    <= 1'b0;
            hitEdge   <= 1'b0;
            from_rom  <= 1'b0;
            cx        <= 8'd0;
            cy        <= 7'd0;
            scan_done <= 1'b0;
            move_left <= 1'b0;
            hold_cnt  <= 8'd0;
        end else begin
            drawEn   <= 1'b0;
            hitEdge  <= 1'b0;
            from_rom <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cx    <= 8'd0;
                        cy    <= 7'd0;
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    xout   <= cx;
                    yout   <= cy;
                    drawEn <= 1'b1;
                    if (cx == X_LAST) begin
                        cx <= 8'd0;
                        if (cy == Y_LAST) begin
                            cy        <= 7'd0;
                            rom_addr  <= 7'd0;
                            scan_done <= 1'b0;
                            state     <= DRAW;
                        end else begin
                            cy <= cy + 7'd1;
                        end
                    end else begin
                        cx <= cx + 8'd1;
                    end
                end
                DRAW, DRAW_NEW: begin
                    if (!scan_done) begin
                        xout     <= xpos + cx;
                        yout     <= Y_ROW + cy;
                        drawEn   <= 1'b1;
                        from_rom <= 1'b1;
                        if (box_last) begin
                            scan_done <= 1'b1;
                        end else begin
                            rom_addr <= rom_addr + 7'd1;
                            if (cx == CX_LAST) begin
                                cx <= 8'd0;
                                cy <= cy + 7'd1;
                            end else begin
                                cx <= cx + 8'd1;
                            end
                        end
                    end else begin
                        // Last pixel is on the outputs this cycle; the pass ends here.
                        cx       <= 8'd0;
                        cy       <= 7'd0;
                        rom_addr <= 7'd0;
                        hold_cnt <= 8'd0;
                        state    <= (state == DRAW) ? READY : HOLD;
                    end
                end
                READY: begin
                    if (left != right) begin
                        move_left <= left;
                        cx        <= 8'd0;
                        cy        <= 7'd0;
                        state     <= ERASE;
                    end
                end
                ERASE: begin
                    xout   <= xpos + cx;
                    yout   <= Y_ROW + cy;
                    drawEn <= 1'b1;
                    if (box_last) begin
                        xpos      <= next_x;
                        hitEdge   <= edge_hit;
                        cx        <= 8'd0;
                        cy        <= 7'd0;
                        rom_addr  <= 7'd0;
                        scan_done <= 1'b0;
                        state     <= DRAW_NEW;
                    end else if (cx == CX_LAST) begin
                        cx <= 8'd0;
                        cy <= cy + 7'd1;
                    end else begin
                        cx <= cx + 8'd1;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state <= READY;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_mover.sv
`default_nettype none
// tb_sprite_mover: pixel-stream model of clear/draw/erase/move checked against sprite_mover every cycle.
module tb_sprite_mover;

    localparam int XS   = 160;
    localparam int YS   = 120;
    localparam int SW   = 11;
    localparam int SH   = 10;
    localparam int X0   = 73;
    localparam int Y0   = 105;
    localparam int STP  = 5;
    localparam int HOLD = 4;
`ifdef SPRITE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic       left;
    logic       right;
    logic [6:0] rom_addr;
    logic [2:0] rom_q;
    logic [7:0] xout;
    logic [6:0] yout;
    logic [2:0] colourOut;
    logic       drawEn;
    logic       ready;
    logic       hitEdge;
    logic [7:0] xpos;

    pix_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   last_pix   = 0;
    int   hit_cnt    = 0;
    int   model_x    = X0;

    sprite_mover dut (
        .clk(clk), .reset(reset), .start(start), .left(left), .right(right),
        .rom_addr(rom_addr), .rom_q(rom_q), .xout(xout), .yout(yout),
        .colourOut(colourOut), .drawEn(drawEn), .ready(ready), .hitEdge(hitEdge),
        .xpos(xpos)
    );

    function automatic logic [2:0] rom_fn(input int a);
        return 3'((a * 5 + 3) % 8);
    endfunction

    always @(posedge clk) rom_q <= rom_fn(int'(rom_addr));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int got, input int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_clear();
        for (int y = 0; y < YS; y++)
            for (int x = 0; x < XS; x++) exp_q.push_back('{x, y, 0});
    endtask

    task automatic push_box(input int x0, input bit black);
        for (int cy = 0; cy < SH; cy++)
            for (int cx = 0; cx < SW; cx++)
                exp_q.push_back('{x0 + cx, Y0 + cy, black ? 0 : int'(rom_fn(cy * SW + cx))});
    endtask

    function automatic void model_next(input int x, input int dir, output int nx, output bit hit);
        int c;
        int mx;
        c   = x + dir * STP;
        mx  = XS - SW;
        hit = (c < 0) || (c > mx);
        if (c < 0) nx = WRAP ? mx : 0;
        else if (c > mx) nx = WRAP ? 0 : mx;
        else nx = c;
    endfunction

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("ready_reached", int'(ready === 1'b1), 1);
    endtask

    // poke: hold 'right' for two cycles inside HOLD, which must be ignored.
    task automatic move(input int dir, input string tag, input bit poke);
        int  nx;
        int  h0;
        int  n;
        bit  hit;
        model_next(model_x, dir, nx, hit);
        push_box(model_x, 1'b1);
        push_box(nx, 1'b0);
        h0 = hit_cnt;
        if (dir < 0) left = 1'b1;
        else right = 1'b1;
        tick();
        left  = 1'b0;
        right = 1'b0;
        if (poke) begin
            n = 0;
            while (exp_q.size() != 0 && n < 400) begin
                tick();
                n++;
            end
            check({tag, "_drain"}, exp_q.size(), 0);
            right = 1'b1;
            tick();
            tick();
            right = 1'b0;
        end
        wait_ready(400);
        model_x = nx;
        check({tag, "_xpos"}, int'(xpos), model_x);
        check({tag, "_pixels_left"}, exp_q.size(), 0);
        check({tag, "_hit_pulses"}, hit_cnt - h0, hit ? 1 : 0);
        check({tag, "_hold_cycles"}, cyc - last_pix - 1, HOLD);
    endtask

    initial begin
        pix_t p;
        int   n;
        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (hitEdge === 1'b1) hit_cnt++;
                if (drawEn === 1'b1) begin
                    last_pix = cyc;
                    compared++;
                    if (exp_q.size() == 0) begin
                        mismatched++;
                        $display("FAIL pixel_extra: got x=%0d y=%0d c=%0d, required no pixel",
                                 xout, yout, colourOut);
                    end else begin
                        p = exp_q.pop_front();
                        if (xout !== 8'(p.x) || yout !== 7'(p.y) || colourOut !== 3'(p.c)) begin
                            mismatched++;
                            $display("FAIL pixel: got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                                     xout, yout, colourOut, p.x, p.y, p.c);
                        end
                    end
                end
            end
        join_none

        reset = 1'b0;
        start = 1'b0;
        left  = 1'b0;
        right = 1'b0;
        repeat (3) tick();
        check("rst_xpos", int'(xpos), 73);
        check("rst_rom_addr", int'(rom_addr), 0);
        check("rst_xout", int'(xout), 0);
        check("rst_yout", int'(yout), 0);
        check("rst_colour", int'(colourOut), 0);
        check("rst_drawEn", int'(drawEn), 0);
        check("rst_hitEdge", int'(hitEdge), 0);
        check("rst_ready", int'(ready), 0);

        reset = 1'b1;
        repeat (5) tick();
        check("idle_no_ready", int'(ready), 0);

        push_clear();
        push_box(X0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_ready(25000);
        check("init_pixels_left", exp_q.size(), 0);
        check("init_xpos", int'(xpos), 73);
        check("init_no_hold", cyc - last_pix - 1, 0);

        move(-1, "left1", 1'b0);
        check("left1_literal", int'(xpos), 68);
        move(1, "right1", 1'b0);
        move(-1, "left_poke", 1'b1);

        // Both commands at once, and the earlier right during HOLD, must do nothing.
        left  = 1'b1;
        right = 1'b1;
        repeat (8) tick();
        left  = 1'b0;
        right = 1'b0;
        repeat (3) tick();
        check("both_ready", int'(ready), 1);
        check("both_xpos", int'(xpos), 68);
        check("both_pixels_left", exp_q.size(), 0);

        for (int i = 0; i < 13; i++) move(-1, "walk", 1'b0);
        check("walk_literal", int'(xpos), 3);
        move(-1, "edge_left", 1'b0);
        check("edge_left_literal", int'(xpos), WRAP ? 149 : 0);
        move(1, "edge_right", 1'b0);
        check("edge_right_literal", int'(xpos), WRAP ? 0 : 5);

        // Abort a redraw partway through with reset.
        begin
            int  nx;
            bit  hit;
            model_next(model_x, -1, nx, hit);
            push_box(model_x, 1'b1);
            push_box(nx, 1'b0);
        end
        left = 1'b1;
        tick();
        left = 1'b0;
        n = 0;
        while (exp_q.size() > 60 && n < 400) begin
            tick();
            n++;
        end
        check("abort_sync", exp_q.size(), 60);
        reset = 1'b0;
        #1;
        check("abort_drawEn", int'(drawEn), 0);
        check("abort_xpos", int'(xpos), 73);
        check("abort_ready", int'(ready), 0);
        exp_q.delete();
        model_x = X0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (20) tick();
        check("abort_idle_ready", int'(ready), 0);

        push_clear();
        push_box(X0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_ready(25000);
        check("restart_pixels_left", exp_q.size(), 0);
        check("restart_xpos", int'(xpos), 73);
        move(1, "restart_right", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
